// File: rtl/hdmi_clock_reconfig.sv
// DRP write-side controller: reprograms the HDMI pixel-clock MMCM for VIC 1/4/16 by read-modify-write over DRP.
// Latency: per register RD + WR issue cycles plus the DRDY waits, then one REL cycle and the LOCKED wait.
// Backpressure: one DRP access outstanding at a time; req is ignored while busy, and DRDY/LOCK stalls are bounded by timeouts.
module hdmi_clock_reconfig #(
    parameter int N_REGS       = 23,
    parameter int DRDY_TIMEOUT = 255,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic        clk_33,
    input  logic        rst_n,
    input  logic        req,
    input  logic [7:0]  vic,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  cur_vic,
    output logic        mmcm_rst,
    input  logic        mmcm_locked,
    output logic [6:0]  daddr,
    output logic        den,
    output logic        dwe,
    output logic [15:0] di,
    input  logic [15:0] do_i,
    input  logic        drdy
);
    localparam int IDX_W  = $clog2(N_REGS);
    localparam int DTMR_W = $clog2(DRDY_TIMEOUT + 1);
    localparam int LTMR_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_WAIT_RD, S_WR, S_WAIT_WR, S_REL, S_WAIT_LOCK, S_DONE, S_ERR
    } state_t;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } drp_ent_t;

    state_t            state;
    logic [1:0]        mode;
    logic [7:0]        vic_l;
    logic [IDX_W-1:0]  idx;
    logic [DTMR_W-1:0] drdy_tmr;
    logic [LTMR_W-1:0] lock_tmr;
    logic [15:0]       rd_dat;
    drp_ent_t          ent;
    logic              vic_ok;
    logic [1:0]        vic_mode;
    logic [6:0]        div_o0, div_o1, div_fb, div_d;
    logic [15:0]       lk0, lk1, lk2, flt0, flt1;

    // Divider encoding: high time = floor(d/2), low time = the remainder, edge = odd divide.
    function automatic logic [15:0] clk_reg1(input logic [6:0] d);
        logic [5:0] hi, lo;
        hi = d[6:1];
        lo = d[5:0] - hi;
        return {4'b0000, hi, lo};
    endfunction

    function automatic logic [15:0] clk_reg2(input logic [6:0] d);
        return {8'h00, d[0], d == 7'd1, 6'b000000};
    endfunction

    function automatic logic [15:0] divclk_reg(input logic [6:0] d);
        logic [5:0] hi, lo;
        hi = d[6:1];
        lo = d[5:0] - hi;
        return {2'b00, d[0], d == 7'd1, hi, lo};
    endfunction

    always_comb begin
        vic_ok   = 1'b1;
        vic_mode = 2'd0;
        case (vic)
            8'd1:    vic_mode = 2'd0;
            8'd4:    vic_mode = 2'd1;
            8'd16:   vic_mode = 2'd2;
            default: vic_ok   = 1'b0;
        endcase
    end

    // 27 MHz reference: VIC1 VCO 756 MHz, VIC4 742.5 MHz, VIC16 1485 MHz; CLKOUT1 is the 5x serial clock.
    always_comb begin
        div_o0 = 7'd30; div_o1 = 7'd6; div_fb = 7'd28; div_d = 7'd1;
        lk0 = 16'h03E8; lk1 = 16'h5801; lk2 = 16'h59E9; flt0 = 16'h0900; flt1 = 16'h1000;
        case (mode)
            2'd1: begin
                div_o0 = 7'd10; div_o1 = 7'd2; div_fb = 7'd55; div_d = 7'd2;
                lk0 = 16'h0226; lk1 = 16'h7C01; lk2 = 16'h7DE9; flt0 = 16'h1900; flt1 = 16'h8890;
            end
            2'd2: begin
                div_o0 = 7'd10; div_o1 = 7'd2; div_fb = 7'd55; div_d = 7'd1;
                lk0 = 16'h0226; lk1 = 16'h7C01; lk2 = 16'h7DE9; flt0 = 16'h1900; flt1 = 16'h8890;
            end
            default: ;
        endcase
    end

    always_comb begin
        ent = '0;
        case (idx)
            5'd0:  ent = '{7'h28, 16'h0000, 16'hFFFF};
            5'd1:  ent = '{7'h08, 16'h1000, clk_reg1(div_o0)};
            5'd2:  ent = '{7'h09, 16'hFC00, clk_reg2(div_o0)};
            5'd3:  ent = '{7'h0A, 16'h1000, clk_reg1(div_o1)};
            5'd4:  ent = '{7'h0B, 16'hFC00, clk_reg2(div_o1)};
            5'd5:  ent = '{7'h0C, 16'h1000, 16'h0041};
            5'd6:  ent = '{7'h0D, 16'hFC00, 16'h0000};
            5'd7:  ent = '{7'h0E, 16'h1000, 16'h0041};
            5'd8:  ent = '{7'h0F, 16'hFC00, 16'h0000};
            5'd9:  ent = '{7'h10, 16'h1000, 16'h0041};
            5'd10: ent = '{7'h11, 16'hFC00, 16'h0000};
            5'd11: ent = '{7'h06, 16'h1000, 16'h0041};
            5'd12: ent = '{7'h07, 16'hFC00, 16'h0000};
            5'd13: ent = '{7'h12, 16'h1000, 16'h0041};
            5'd14: ent = '{7'h13, 16'hFC00, 16'h0000};
            5'd15: ent = '{7'h16, 16'hC000, divclk_reg(div_d)};
            5'd16: ent = '{7'h14, 16'h1000, clk_reg1(div_fb)};
            5'd17: ent = '{7'h15, 16'hFC00, clk_reg2(div_fb)};
            5'd18: ent = '{7'h18, 16'hFC00, lk0};
            5'd19: ent = '{7'h19, 16'h8000, lk1};
            5'd20: ent = '{7'h1A, 16'h8000, lk2};
            5'd21: ent = '{7'h4E, 16'h66FF, flt0};
            5'd22: ent = '{7'h4F, 16'h666F, flt1};
            default: ent = '0;
        endcase
    end

    always_ff @(posedge clk_33 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mode     <= 2'd0;
            vic_l    <= 8'd1;
            idx      <= '0;
            drdy_tmr <= '0;
            lock_tmr <= '0;
            rd_dat   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cur_vic  <= 8'd1;
            mmcm_rst <= 1'b0;
            daddr    <= '0;
            den      <= 1'b0;
            dwe      <= 1'b0;
            di       <= '0;
        end else begin
            done <= 1'b0;
            den  <= 1'b0;
            dwe  <= 1'b0;
            case (state)
                S_IDLE: if (req) begin
                    if (vic_ok) begin
                        mode     <= vic_mode;
                        vic_l    <= vic;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        mmcm_rst <= 1'b1;
                        idx      <= '0;
                        state    <= S_RD;
                    end else begin
                        error <= 1'b1;
                    end
                end
                S_RD: begin
                    den      <= 1'b1;
                    daddr    <= ent.addr;
                    drdy_tmr <= '0;
                    state    <= S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    if (drdy) begin
                        rd_dat <= do_i;
                        state  <= S_WR;
                    end else if (drdy_tmr == DTMR_W'(DRDY_TIMEOUT)) begin
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        mmcm_rst <= 1'b0;
                        state    <= S_ERR;
                    end else begin
                        drdy_tmr <= drdy_tmr + 1'b1;
                    end
                end
                S_WR: begin
                    den      <= 1'b1;
                    dwe      <= 1'b1;
                    di       <= (rd_dat & ent.mask) | ent.data;
                    drdy_tmr <= '0;
                    state    <= S_WAIT_WR;
                end
                S_WAIT_WR: begin
                    if (drdy) begin
                        if (idx == IDX_W'(N_REGS - 1)) begin
                            state <= S_REL;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_RD;
                        end
                    end else if (drdy_tmr == DTMR_W'(DRDY_TIMEOUT)) begin
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        mmcm_rst <= 1'b0;
                        state    <= S_ERR;
                    end else begin
                        drdy_tmr <= drdy_tmr + 1'b1;
                    end
                end
                S_REL: begin
                    mmcm_rst <= 1'b0;
                    lock_tmr <= '0;
                    state    <= S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (mmcm_locked) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cur_vic <= vic_l;
                        state   <= S_DONE;
                    end else if (lock_tmr == LTMR_W'(LOCK_TIMEOUT)) begin
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        mmcm_rst <= 1'b0;
                        state    <= S_ERR;
                    end else begin
                        lock_tmr <= lock_tmr + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hdmi_clock_reconfig.sv
// Bench for hdmi_clock_reconfig: DRP slave and MMCM lock models, with a scoreboard of expected DRP accesses.
module tb_hdmi_clock_reconfig;
    logic        clk_33 = 1'b0;
    logic        rst_n;
    logic        req;
    logic [7:0]  vic;
    logic        busy, done, error, mmcm_rst, den, dwe;
    logic [7:0]  cur_vic;
    logic        mmcm_locked;
    logic [6:0]  daddr;
    logic [15:0] di, do_i;
    logic        drdy;

    always #15 clk_33 = ~clk_33;

    hdmi_clock_reconfig dut (
        .clk_33(clk_33), .rst_n(rst_n), .req(req), .vic(vic),
        .busy(busy), .done(done), .error(error), .cur_vic(cur_vic),
        .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked),
        .daddr(daddr), .den(den), .dwe(dwe), .di(di), .do_i(do_i), .drdy(drdy)
    );

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] dat;
    } drp_txn_t;

    localparam logic [6:0] T_ADDR [23] = '{
        7'h28, 7'h08, 7'h09, 7'h0A, 7'h0B, 7'h0C, 7'h0D, 7'h0E, 7'h0F, 7'h10, 7'h11, 7'h06,
        7'h07, 7'h12, 7'h13, 7'h16, 7'h14, 7'h15, 7'h18, 7'h19, 7'h1A, 7'h4E, 7'h4F};
    localparam logic [15:0] T_MASK [23] = '{
        16'h0000, 16'h1000, 16'hFC00, 16'h1000, 16'hFC00, 16'h1000, 16'hFC00, 16'h1000,
        16'hFC00, 16'h1000, 16'hFC00, 16'h1000, 16'hFC00, 16'h1000, 16'hFC00, 16'hC000,
        16'h1000, 16'hFC00, 16'hFC00, 16'h8000, 16'h8000, 16'h66FF, 16'h666F};
    // Hand-derived register images: VIC1 O0=30 O1=6 M=28 D=1; VIC4 O0=10 O1=2 M=55 D=2; VIC16 as VIC4 with D=1.
    localparam logic [15:0] T_DATA [3][23] = '{
        '{16'hFFFF, 16'h03CF, 16'h0000, 16'h00C3, 16'h0000, 16'h0041, 16'h0000, 16'h0041,
          16'h0000, 16'h0041, 16'h0000, 16'h0041, 16'h0000, 16'h0041, 16'h0000, 16'h3001,
          16'h038E, 16'h0000, 16'h03E8, 16'h5801, 16'h59E9, 16'h0900, 16'h1000},
        '{16'hFFFF, 16'h0145, 16'h0000, 16'h0041, 16'h0000, 16'h0041, 16'h0000, 16'h0041,
          16'h0000, 16'h0041, 16'h0000, 16'h0041, 16'h0000, 16'h0041, 16'h0000, 16'h0041,
          16'h06DC, 16'h0080, 16'h0226, 16'h7C01, 16'h7DE9, 16'h1900, 16'h8890},
        '{16'hFFFF, 16'h0145, 16'h0000, 16'h0041, 16'h0000, 16'h0041, 16'h0000, 16'h0041,
          16'h0000, 16'h0041, 16'h0000, 16'h0041, 16'h0000, 16'h0041, 16'h0000, 16'h3001,
          16'h06DC, 16'h0080, 16'h0226, 16'h7C01, 16'h7DE9, 16'h1900, 16'h8890}};

    drp_txn_t    sb[$];
    logic [15:0] mem [128];
    int checks = 0, errors = 0;
    int den_cnt = 0, seq_den = 0, done_cnt = 0, cyc = 0;
    int stall_den = 0, stall_cyc = 0, lock_cnt = 0;
    bit stall_en = 1'b0, lock_en = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_33) cyc <= cyc + 1;
    always @(negedge clk_33) if (done) done_cnt <= done_cnt + 1;

    // DRP slave: answers each den with drdy three cycles later unless told to stall.
    initial begin
        int          pend;
        logic [6:0]  paddr;
        drp_txn_t    e;
        pend = 0; paddr = '0; drdy = 1'b0; do_i = '0;
        forever begin
            @(negedge clk_33);
            drdy = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else if (den) begin
                den_cnt++;
                check_eq("sb_has_entry", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("dwe", dwe, e.we);
                    check_eq("daddr", daddr, e.addr);
                    if (e.we) check_eq("di", di, e.dat);
                end
                check_eq("rst_held", mmcm_rst, 1);
                if (dwe) mem[daddr] = di;
                if (stall_en && seq_den == stall_den) stall_cyc = cyc;
                else begin
                    pend  = 3;
                    paddr = daddr;
                end
                seq_den++;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    drdy = 1'b1;
                    do_i = mem[paddr];
                end
            end
        end
    end

    initial begin
        mmcm_locked = 1'b0;
        forever begin
            @(negedge clk_33);
            if (mmcm_rst || !lock_en) lock_cnt = 0;
            else if (lock_cnt < 100) lock_cnt++;
            mmcm_locked = (lock_cnt >= 8);
        end
    end

    task automatic start_req(input logic [7:0] v);
        int m;
        m = (v == 8'd1) ? 0 : (v == 8'd4) ? 1 : (v == 8'd16) ? 2 : -1;
        @(negedge clk_33);
        if (m >= 0) begin
            seq_den = 0;
            for (int i = 0; i < 23; i++) begin
                sb.push_back('{1'b0, T_ADDR[i], 16'h0000});
                sb.push_back('{1'b1, T_ADDR[i], (mem[T_ADDR[i]] & T_MASK[i]) | T_DATA[m][i]});
            end
        end
        req = 1'b1;
        vic = v;
        @(negedge clk_33);
        req = 1'b0;
        vic = 8'd0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk_33);
            if (done) seen = 1'b1;
        end
        check_eq(tag, seen, 1);
        @(negedge clk_33);
        check_eq({tag, "_pulse_len"}, done, 0);
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (busy && n < bound) begin
            @(negedge clk_33);
            n++;
        end
    endtask

    initial begin
        int  n, d0, dc0;
        bit  found;
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        rst_n = 1'b0; req = 1'b0; vic = 8'd0;
        repeat (3) @(negedge clk_33);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_cur_vic", cur_vic, 1);
        check_eq("rst_mmcm_rst", mmcm_rst, 0);
        check_eq("rst_daddr", daddr, 0);
        check_eq("rst_den", den, 0);
        check_eq("rst_dwe", dwe, 0);
        check_eq("rst_di", di, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_33);

        // VIC 4 full switch
        start_req(8'd4);
        check_eq("v4_busy", busy, 1);
        check_eq("v4_mmcm_rst", mmcm_rst, 1);
        wait_done("v4_done", 2000);
        check_eq("v4_den_cnt", seq_den, 46);
        check_eq("v4_cur_vic", cur_vic, 4);
        check_eq("v4_sb_empty", sb.size(), 0);
        check_eq("v4_busy_end", busy, 0);
        check_eq("v4_error", error, 0);

        // Unsupported code
        d0 = den_cnt;
        start_req(8'd7);
        check_eq("v7_error", error, 1);
        check_eq("v7_busy", busy, 0);
        repeat (20) @(negedge clk_33);
        check_eq("v7_no_den", den_cnt, d0);
        check_eq("v7_cur_vic", cur_vic, 4);

        // LOCKED never arrives
        lock_en = 1'b0;
        dc0 = done_cnt;
        start_req(8'd16);
        check_eq("lkto_error_clr", error, 0);
        check_eq("lkto_busy", busy, 1);
        for (int i = 0; i < 2000 && seq_den < 46; i++) @(negedge clk_33);
        repeat (100) @(negedge clk_33);
        check_eq("lkto_rst_released", mmcm_rst, 0);
        check_eq("lkto_still_busy", busy, 1);
        wait_idle(70000, n);
        check_eq("lkto_error", error, 1);
        check_eq("lkto_busy_end", busy, 0);
        check_eq("lkto_window", (n > 65300 && n < 66000), 1);
        check_eq("lkto_no_done", done_cnt, dc0);
        check_eq("lkto_cur_vic", cur_vic, 4);

        // Retry VIC 16 with lock
        lock_en = 1'b1;
        repeat (2) @(negedge clk_33);
        start_req(8'd16);
        check_eq("v16_error_clr", error, 0);
        wait_done("v16_done", 2000);
        check_eq("v16_cur_vic", cur_vic, 16);
        check_eq("v16_sb_empty", sb.size(), 0);

        // DRDY never returns on the idx 5 read
        stall_en = 1'b1;
        stall_den = 10;
        start_req(8'd1);
        wait_idle(2000, n);
        check_eq("drto_error", error, 1);
        check_eq("drto_busy", busy, 0);
        check_eq("drto_mmcm_rst", mmcm_rst, 0);
        check_eq("drto_window", (cyc - stall_cyc >= 250 && cyc - stall_cyc <= 262), 1);
        repeat (50) @(negedge clk_33);
        check_eq("drto_no_more_den", seq_den, 11);
        check_eq("drto_cur_vic", cur_vic, 16);
        stall_en = 1'b0;
        sb.delete();

        // req while busy is dropped
        start_req(8'd1);
        for (int i = 0; i < 200 && seq_den < 4; i++) @(negedge clk_33);
        check_eq("busy_req_busy", busy, 1);
        req = 1'b1;
        vic = 8'd16;
        @(negedge clk_33);
        req = 1'b0;
        vic = 8'd0;
        wait_done("v1_done", 2000);
        check_eq("v1_den_cnt", seq_den, 46);
        check_eq("v1_cur_vic", cur_vic, 1);
        check_eq("v1_sb_empty", sb.size(), 0);
        check_eq("v1_error", error, 0);
        repeat (20) @(negedge clk_33);
        check_eq("v1_no_requeue", busy, 0);

        // Async reset on the idx 10 read
        start_req(8'd4);
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk_33);
            if (den && !dwe && daddr == 7'h11) found = 1'b1;
        end
        check_eq("arst_found", found, 1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_den", den, 0);
        check_eq("arst_mmcm_rst", mmcm_rst, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_cur_vic", cur_vic, 1);
        check_eq("arst_daddr", daddr, 0);
        @(negedge clk_33);
        rst_n = 1'b1;
        sb.delete();
        repeat (5) @(negedge clk_33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
